// File: rtl/mem_block_responder.sv
// -----------------------------------------------------------------------------
// mem_block_responder
//
// Services one cache block-fill request at a time. On an accepted request the
// block waits out the programmed access latency, then issues eight consecutive
// SRAM reads covering the aligned 16-byte block containing req_addr. It
// returns the eight read words to the fill controller one per cycle.
//
// Parameters
//   LATENCY     cycles from request acceptance to the first data_valid (2..15)
//
// Ports
//   clk         single clock, rising-edge active
//   rst         asynchronous, active-high reset
//   req         block-fill request, sampled only while idle
//   req_addr    byte address that missed; bits [3:0] are ignored
//   busy        high while a block transfer is in progress
//   data_out    returned word, zero whenever data_valid is low
//   data_valid  one-cycle strobe per returned word
//   word_num    index 0..7 of the word on data_out, zero when data_valid is low
//   mem_rd      read strobe to the backing SRAM
//   mem_addr    SRAM byte address, zero when mem_rd is low
//   mem_rdata   SRAM read data, valid the cycle after mem_rd
// -----------------------------------------------------------------------------
module mem_block_responder #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] req_addr,
  output logic        busy,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [2:0]  word_num,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // WAIT lasts LATENCY-2 cycles. The counter is loaded with one less than that
  // and WAIT exits on the cycle it reads zero. With LATENCY=2 WAIT is skipped
  // entirely, so the load value is never used.
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 2) ? 4'(LATENCY - 3) : 4'd0;

  state_t      state_q, state_d;
  logic [11:0] base_q,  base_d;   // block address bits [15:4]
  logic [2:0]  k_q,     k_d;      // word counter within the block
  logic [3:0]  wait_q,  wait_d;   // remaining WAIT cycles minus one
  logic        data_valid_q, data_valid_d;
  logic [2:0]  word_num_q,   word_num_d;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    base_d  = base_q;
    k_d     = k_q;
    wait_d  = wait_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          base_d = req_addr[15:4];
          k_d    = 3'd0;
          wait_d = WAIT_LOAD;
          if (LATENCY == 2) state_d = S_READ;
          else              state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) state_d = S_READ;
        else                wait_d  = wait_q - 4'd1;
      end
      S_READ: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign mem_rd = (state_q == S_READ);

  // The word offset occupies bits [3:0] alone, so stepping through the block
  // can never carry into the block address held in base_q.
  assign mem_addr = mem_rd ? {base_q, k_q, 1'b0} : 16'h0000;

  // The return path is one register stage behind the read strobe, which lines
  // data_valid up with the cycle in which the SRAM presents the read data.
  assign data_valid_d = mem_rd;
  assign word_num_d   = mem_rd ? k_q : 3'd0;

  assign data_valid = data_valid_q;
  assign word_num   = word_num_q;
  assign data_out   = data_valid_q ? mem_rdata : 16'h0000;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= 12'h000;
      k_q          <= 3'd0;
      wait_q       <= 4'd0;
      data_valid_q <= 1'b0;
      word_num_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      k_q          <= k_d;
      wait_q       <= wait_d;
      data_valid_q <= data_valid_d;
      word_num_q   <= word_num_d;
    end
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_block_responder
//
// Directed bench for mem_block_responder. Three instances run with LATENCY 4,
// 2 and 15 on a shared clock and reset. Each instance has its own request
// inputs and its own SRAM model, which answers any address with addr^16'hA5A5
// one cycle after the address appears. Outputs are sampled on the falling
// edge. Cycle c below is the interval that follows acceptance edge A+c.
// -----------------------------------------------------------------------------
module tb_mem_block_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]        req_v;
  logic [2:0][15:0]  addr_v;
  logic [2:0][15:0]  rdata_v;
  logic [2:0]        busy_v;
  logic [2:0][15:0]  dout_v;
  logic [2:0]        dv_v;
  logic [2:0][2:0]   wn_v;
  logic [2:0]        rd_v;
  logic [2:0][15:0]  maddr_v;

  int tests = 0;
  int fails = 0;

  mem_block_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req(req_v[0]), .req_addr(addr_v[0]),
    .busy(busy_v[0]), .data_out(dout_v[0]), .data_valid(dv_v[0]),
    .word_num(wn_v[0]), .mem_rd(rd_v[0]), .mem_addr(maddr_v[0]),
    .mem_rdata(rdata_v[0])
  );

  mem_block_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req(req_v[1]), .req_addr(addr_v[1]),
    .busy(busy_v[1]), .data_out(dout_v[1]), .data_valid(dv_v[1]),
    .word_num(wn_v[1]), .mem_rd(rd_v[1]), .mem_addr(maddr_v[1]),
    .mem_rdata(rdata_v[1])
  );

  mem_block_responder #(.LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst), .req(req_v[2]), .req_addr(addr_v[2]),
    .busy(busy_v[2]), .data_out(dout_v[2]), .data_valid(dv_v[2]),
    .word_num(wn_v[2]), .mem_rd(rd_v[2]), .mem_addr(maddr_v[2]),
    .mem_rdata(rdata_v[2])
  );

  // SRAM models: data for the address presented in one cycle arrives the next.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rdata_v[i] <= maddr_v[i] ^ 16'hA5A5;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int w, input string tag);
    check({tag, " busy"},       16'(busy_v[w]), 16'h0000);
    check({tag, " data_valid"}, 16'(dv_v[w]),   16'h0000);
    check({tag, " mem_rd"},     16'(rd_v[w]),   16'h0000);
    check({tag, " mem_addr"},   maddr_v[w],     16'h0000);
    check({tag, " data_out"},   dout_v[w],      16'h0000);
    check({tag, " word_num"},   16'(wn_v[w]),   16'h0000);
  endtask

  // Raises req at the current falling edge, so the next rising edge is the
  // acceptance edge A, then checks every output for cycles 0..lat+7 against
  // the expected timeline. With hold=1, req stays high and the call ends with
  // the instance idle and about to accept again. With pulses=1, req is
  // re-pulsed at edges A+3 and A+6, which must be ignored.
  task automatic xfer(input int w, input int lat, input logic [15:0] addr,
                      input bit hold, input bit pulses, input string tag,
                      output logic [15:0] first_dout, output logic [15:0] last_addr);
    logic [15:0] base, exp_addr, exp_dout;
    logic        exp_busy, exp_rd, exp_dv;
    int          wn, n_dv;
    string       t;
    base       = {addr[15:4], 4'h0};
    n_dv       = 0;
    first_dout = 16'hxxxx;
    last_addr  = 16'hxxxx;
    req_v[w]   = 1'b1;
    addr_v[w]  = addr;
    for (int c = 0; c <= lat + 7; c++) begin
      @(negedge clk);
      if (!hold) begin
        req_v[w] = pulses && (c == 2 || c == 5);
        if (c == 0) addr_v[w] = ~addr;
      end
      exp_busy = (c <= lat + 6);
      exp_rd   = (c >= lat - 2) && (c <= lat + 5);
      exp_addr = exp_rd ? base + 16'(2 * (c - (lat - 2))) : 16'h0000;
      exp_dv   = (c >= lat - 1) && (c <= lat + 6);
      wn       = exp_dv ? c - (lat - 1) : 0;
      exp_dout = exp_dv ? ((base + 16'(2 * wn)) ^ 16'hA5A5) : 16'h0000;
      t = $sformatf("%s c%0d", tag, c);
      check({t, " busy"},       16'(busy_v[w]), 16'(exp_busy));
      check({t, " mem_rd"},     16'(rd_v[w]),   16'(exp_rd));
      check({t, " mem_addr"},   maddr_v[w],     exp_addr);
      check({t, " data_valid"}, 16'(dv_v[w]),   16'(exp_dv));
      check({t, " word_num"},   16'(wn_v[w]),   16'(wn));
      check({t, " data_out"},   dout_v[w],      exp_dout);
      if (dv_v[w] === 1'b1) begin
        n_dv++;
        if (n_dv == 1) first_dout = dout_v[w];
      end
      if (rd_v[w] === 1'b1) last_addr = maddr_v[w];
    end
    check({tag, " word count"}, 16'(n_dv), 16'd8);
  endtask

  logic [15:0] fd, la, fd2, la2;

  initial begin
    rst    = 1'b1;
    req_v  = '0;
    addr_v = '0;

    // Reset state, with req high to show it is ignored under reset.
    repeat (2) @(negedge clk);
    req_v = 3'b111;
    @(negedge clk);
    check_idle(0, "reset l4");
    check_idle(1, "reset l2");
    check_idle(2, "reset l15");
    req_v = '0;
    rst   = 1'b0;
    @(negedge clk);
    check_idle(0, "post-reset l4");

    // LATENCY=4, unaligned address, single-cycle req, address scrambled after.
    xfer(0, 4, 16'h1236, 1'b0, 1'b0, "l4 basic", fd, la);
    check("l4 basic first data_out", fd, 16'hB795);
    check("l4 basic last mem_addr",  la, 16'h123E);

    // LATENCY=2 at the top block: no WAIT, no carry out of the offset.
    xfer(1, 2, 16'hFFF8, 1'b0, 1'b0, "l2 top", fd, la);
    check("l2 top first data_out", fd, 16'h5A55);
    check("l2 top last mem_addr",  la, 16'hFFFE);

    // Requests during a transfer are dropped, not queued.
    xfer(0, 4, 16'h8000, 1'b0, 1'b1, "l4 pulses", fd, la);
    repeat (6) begin
      @(negedge clk);
      check_idle(0, "l4 pulses after");
    end

    // req held high: the second acceptance edge is the first idle edge.
    xfer(0, 4, 16'h2A50, 1'b1, 1'b0, "l4 b2b first",  fd, la);
    xfer(0, 4, 16'h3C0F, 1'b0, 1'b0, "l4 b2b second", fd2, la2);
    check("l4 b2b second first data_out", fd2, 16'h3C00 ^ 16'hA5A5);
    check("l4 b2b second last mem_addr",  la2, 16'h3C0E);

    // LATENCY=15: thirteen WAIT cycles, first word at A+15.
    xfer(2, 15, 16'h0040, 1'b0, 1'b0, "l15", fd, la);
    check("l15 first data_out", fd, 16'h0040 ^ 16'hA5A5);

    // Reset during word 3 aborts immediately; afterwards the block stays idle.
    @(negedge clk);
    req_v[0]  = 1'b1;
    addr_v[0] = 16'h4A70;
    @(negedge clk);
    req_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("abort pre data_valid", 16'(dv_v[0]), 16'h0001);
    check("abort pre word_num",   16'(wn_v[0]), 16'h0003);
    #2 rst = 1'b1;
    #1;
    check_idle(0, "abort in reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_idle(0, "abort released");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a hung simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
